// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Timeout sizing is only consumed when LSU_TIMEOUT_EN is defined.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    // Fields of an accepted op needed to finish a load
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] off;
        logic [4:0] rd;
    } lsu_req_t;

    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: store replication / byte enables and load byte/half
// selection with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_data,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate the datum across every lane it may land in
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = st_data;
        case (st_size)
            2'b00: begin
                be_c    = 4'b0001 << st_off;
                wdata_c = {4{st_data[7:0]}};
            end
            2'b01: begin
                be_c    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_data[7:0];
        case (ld_off)
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            2'd3:    ld_byte = ld_data[31:24];
            default: ;
        endcase
        ld_half = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    end

    always_comb begin
        rdata_c = ld_data;
        case (ld_funct3)
            LB:      rdata_c = {{24{ld_byte[7]}}, ld_byte};
            LH:      rdata_c = {{16{ld_half[15]}}, ld_half};
            LBU:     rdata_c = {24'd0, ld_byte};
            LHU:     rdata_c = {16'd0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit between execute and data memory.
// Define LSU_TIMEOUT_EN to add the TIMEOUT_CYCLES bus-timeout watchdog.
module lsu
    import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_cause
);

    lsu_state_e  state, state_next;
    lsu_err_e    cause_c;
    lsu_req_t    req;
    logic        err_c, accept_c, illegal_c, misalign_c;
    logic [3:0]  be_c;
    logic [31:0] st_data_c, ld_data_c;

    lsu_align u_align (
        .st_size   (funct3[1:0]),
        .st_off    (addr[1:0]),
        .st_data   (wdata),
        .ld_funct3 (req.funct3),
        .ld_off    (req.off),
        .ld_data   (dmem_rdata),
        .be_c      (be_c),
        .wdata_c   (st_data_c),
        .rdata_c   (ld_data_c)
    );

    // Legality of the op currently offered by execute
    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        if (mem_rd && mem_wr) begin
            illegal_c = 1'b1;
        end else if (mem_rd) begin
            illegal_c = !(funct3 inside {LB, LH, LW, LBU, LHU});
        end else if (mem_wr) begin
            illegal_c = !(funct3 inside {SB, SH, SW});
        end
        case (funct3[1:0])
            2'b01:   misalign_c = addr[0];
            2'b10:   misalign_c = |addr[1:0];
            default: ;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO_W = tmo_cnt_width(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept_c) begin
            tmo_cnt <= '0;
        end else if (state == ST_REQ && !dmem_ack) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        err_c      = 1'b0;
        cause_c    = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (ex_valid && (mem_rd || mem_wr)) begin
                    if (illegal_c) begin
                        err_c   = 1'b1;
                        cause_c = ERR_ILLEGAL;
                    end else if (misalign_c) begin
                        err_c   = 1'b1;
                        cause_c = ERR_MISALIGN;
                    end else begin
                        accept_c   = 1'b1;
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    if (dmem_we) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
`ifdef LSU_TIMEOUT_EN
                // An ack in the expiring cycle still completes normally
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                    err_c      = 1'b1;
                    cause_c    = ERR_TIMEOUT;
                end
`endif
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            req           <= '0;
            ex_ready      <= 1'b1;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            lsu_err       <= 1'b0;
            lsu_err_cause <= ERR_NONE;
        end else begin
            state         <= state_next;
            ex_ready      <= (state_next == ST_IDLE);
            dmem_req      <= (state_next == ST_REQ);
            wb_valid      <= (state_next == ST_RESP);
            lsu_err       <= err_c;
            lsu_err_cause <= cause_c;
            if (accept_c) begin
                req        <= '{funct3: funct3, off: addr[1:0], rd: rd_addr};
                dmem_we    <= mem_wr;
                dmem_addr  <= {addr[31:2], 2'b00};
                dmem_wdata <= mem_wr ? st_data_c : 32'd0;
                dmem_be    <= be_c;
            end
            if (state == ST_REQ && dmem_ack && !dmem_we) begin
                wb_data <= ld_data_c;
                wb_rd   <= req.rd;
            end
        end
    end

endmodule
